pwm_capture: RTL

- Measures an external or looped-back PWM waveform: period and high time, in CLK cycles.
- Receive-side counterpart of the breathing-LED PWM generator.
- Used to self-check LED drive and to read duty from off-board PWM sources.
- Reports one result per completed period with a one-cycle VALID strobe, and flags a stuck (0 % / 100 %) input.

---
 rtl/pwm_capture.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input in clock cycles.
// One result per completed period is reported with a single-cycle valid strobe.
// A stuck (0 % / 100 %) input is flagged after a programmable number of cycles
// without a qualifying edge, along with the level the input was stuck at.
module pwm_capture #(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned TIMEOUT = 5000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pwm_in,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_t,
    output logic             o_valid,
    output logic             o_stuck,
    output logic             o_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [1:0]       WARM_CYCLES = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST_H,
        ST_FIRST_L,
        ST_HIGH,
        ST_LOW
    } state_t;

    // Synchronizer chain and edge-detect history
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [1:0]       r_warm;

    // Measurement state
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    state_t           r_state;
    state_t           w_state_nxt;

    // Registered outputs
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_t;
    logic             r_valid;
    logic             r_stuck;
    logic             r_level;

    // Decoded events
    logic             w_warm_done;
    logic             w_rise;
    logic             w_fall;
    logic             w_cnt_sat;
    logic             w_timeout;
    logic             w_report;
    logic             w_hi_capture;

    // Edges are suppressed until the history flop holds a real sample, so an
    // input that is already high at reset release is not seen as a rise.
    assign w_warm_done  = (r_warm == WARM_CYCLES);
    assign w_rise       = w_warm_done &  r_sync2 & ~r_sync3;
    assign w_fall       = w_warm_done & ~r_sync2 &  r_sync3;
    assign w_cnt_sat    = (r_cnt == TIMEOUT_C);

    // An edge coinciding with saturation wins; an already-stuck idle input
    // does not keep re-arming the timeout.
    assign w_timeout    = w_cnt_sat & ~w_rise & ~w_fall
                        & ~((r_state == ST_IDLE) & r_stuck);
    assign w_report     = (r_state == ST_LOW)  & w_rise;
    assign w_hi_capture = (r_state == ST_HIGH) & w_fall;

    // Two-flop synchronizer followed by the previous-sample flop for edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_pwm_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Warm-up counter: gates edge detection for the first cycles after reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_warm <= 2'd0;
        end else if (!w_warm_done) begin
            r_warm <= r_warm + 2'd1;
        end
    end

    // Cycle counter: restarts at 1 on every rise, otherwise saturates at TIMEOUT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_ONE;
        end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // High-time capture on the falling edge of a tracked period
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi_cnt <= '0;
        end else if (w_hi_capture) begin
            r_hi_cnt <= r_cnt;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the period started after IDLE is always discarded
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_state_nxt = ST_FIRST_H;
            end
            ST_FIRST_H: begin
                if (w_fall) w_state_nxt = ST_FIRST_L;
            end
            ST_FIRST_L: begin
                if (w_rise) w_state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_fall) w_state_nxt = ST_LOW;
            end
            ST_LOW: begin
                if (w_rise) w_state_nxt = ST_HIGH;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Result registers: publish on a full period, clear and flag on timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period <= '0;
            r_high_t <= '0;
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
            r_level  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_report) begin
                r_period <= r_cnt;
                r_high_t <= r_hi_cnt;
                r_valid  <= 1'b1;
                r_stuck  <= 1'b0;
                r_level  <= 1'b0;
            end else if (w_timeout) begin
                r_period <= '0;
                r_high_t <= '0;
                r_stuck  <= 1'b1;
                r_level  <= r_sync2;
            end
        end
    end

    assign o_period = r_period;
    assign o_high_t = r_high_t;
    assign o_valid  = r_valid;
    assign o_stuck  = r_stuck;
    assign o_level  = r_level;

endmodule
